// File: rtl/edge_pkg.sv
// Shared constants and width helpers for the edge_stream_core slice.
//   - Kernel mode encodings (mode 3 is reserved and runs as Sobel).
//   - Centre-row/column weights of the two gradient kernels.
//   - Read-side FSM state type.
//   - Width helpers used to size counters from the module parameters.
package edge_pkg;

  localparam logic [1:0] MODE_SOBEL   = 2'd0;
  localparam logic [1:0] MODE_PREWITT = 2'd1;
  localparam logic [1:0] MODE_PASS    = 2'd2;

  // Both kernels are [1 w 1] smoothing x [-1 0 1] difference; only w differs.
  localparam int SOBEL_CENTRE_W   = 2;
  localparam int PREWITT_CENTRE_W = 1;

  // Headroom bits above DATA_W for the signed gradients and their magnitude.
  localparam int GRAD_GUARD = 4;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_RUN,
    RD_DRAIN
  } rd_state_t;

  // Bits needed to index n items (at least 1).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a count 0..n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/line_ram.sv
// One image line of storage: simple dual-port RAM, DEPTH x DATA_W.
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write column
//   wdata  in   write pixel
//   re     in   read enable; rdata holds its value while re=0
//   raddr  in   read column
//   rdata  out  pixel at raddr, one cycle after the read is issued
module line_ram
  import edge_pkg::*;
#(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 8,
  localparam int AW    = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array and its read register are not reset -- contents before the
  // first write are never consumed, and a reset would block RAM inference.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/edge_stream_core.sv
// Streaming 3x3 edge detector (Sobel / Prewitt / passthrough, optional threshold).
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   TVALID_sub/TDATA_sub/    pixel input stream, raster order, IMG_W per line
//   TREADY_sub
//   TVALID_man/TDATA_man/    pixel output stream; TLAST_man on last column
//   TLAST_man/TREADY_man
//   mode, thresh_en, thresh  kernel select and binarisation, sampled per pass
//   INT                      one-cycle pulse each time a line buffer is freed
// Lines are written round-robin into NUM_LINES buffers. Once three full lines
// are held, a pass reads them column by column, forms a zero-padded 3x3
// window and emits the result for the centre line.
module edge_stream_core
  import edge_pkg::*;
#(
  parameter int IMG_W     = 512,
  parameter int DATA_W    = 8,
  parameter int NUM_LINES = 4
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              TVALID_sub,
  input  logic [DATA_W-1:0] TDATA_sub,
  output logic              TREADY_sub,
  output logic              TVALID_man,
  output logic [DATA_W-1:0] TDATA_man,
  output logic              TLAST_man,
  input  logic              TREADY_man,
  input  logic [1:0]        mode,
  input  logic              thresh_en,
  input  logic [DATA_W-1:0] thresh,
  output logic              INT
);

  localparam int COL_W  = idx_w(IMG_W);
  localparam int STEP_W = cnt_w(IMG_W);
  localparam int LINE_W = idx_w(NUM_LINES);
  localparam int FILL_W = cnt_w(NUM_LINES);
  localparam int GW     = DATA_W + GRAD_GUARD;

  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(IMG_W);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(NUM_LINES);
  localparam logic [FILL_W-1:0] FILL_RUN  = FILL_W'(3);

  function automatic logic [LINE_W-1:0] line_add(input logic [LINE_W-1:0] l, input int k);
    int t;
    t = int'(l) + k;
    if (t >= NUM_LINES) t = t - NUM_LINES;
    return LINE_W'(t);
  endfunction

  // ---------------------------------------------------------------- write side
  logic              wr_fire, line_done, pass_done;
  logic [COL_W-1:0]  wr_col;
  logic [LINE_W-1:0] wr_line;
  logic [FILL_W-1:0] fill_cnt, fill_next;

  assign wr_fire   = TVALID_sub & TREADY_sub;
  assign line_done = wr_fire & (wr_col == LAST_COL);

  // A line arriving in the same cycle one is released leaves the count as is.
  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    fill_next = fill_cnt;
    if (line_done && !pass_done)      fill_next = fill_cnt + FILL_W'(1);
    else if (pass_done && !line_done) fill_next = fill_cnt - FILL_W'(1);
  end

  // TREADY_sub is registered from the next count, so it is low during reset
  // and tracks (fill_cnt < NUM_LINES) from the first edge afterwards.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_col     <= '0;
      wr_line    <= '0;
      fill_cnt   <= '0;
      TREADY_sub <= 1'b0;
    end else begin
      fill_cnt   <= fill_next;
      TREADY_sub <= (fill_next < FILL_MAX);
      if (line_done) begin
        wr_col  <= '0;
        wr_line <= line_add(wr_line, 1);
      end else if (wr_fire) begin
        wr_col <= wr_col + COL_W'(1);
      end
    end
  end

  // ----------------------------------------------------------------- read FSM
  rd_state_t         rd_state, rd_state_nxt;
  logic [STEP_W-1:0] step;
  logic [LINE_W-1:0] rd_base;
  logic              en, pass_start, step_issue;
  logic [1:0]        cfg_mode;
  logic              cfg_te;
  logic [DATA_W-1:0] cfg_th;

  // The whole read pipeline moves only when the output register can move.
  assign en = ~TVALID_man | TREADY_man;

  always_comb begin
    rd_state_nxt = rd_state;
    pass_start   = 1'b0;
    step_issue   = 1'b0;
    pass_done    = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        if (fill_cnt >= FILL_RUN) begin
          pass_start   = 1'b1;
          rd_state_nxt = RD_RUN;
        end
      end
      RD_RUN: begin
        if (en) begin
          step_issue = 1'b1;
          if (step == LAST_STEP) rd_state_nxt = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (TVALID_man && TREADY_man && TLAST_man) begin
          pass_done    = 1'b1;
          rd_state_nxt = RD_IDLE;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state <= RD_IDLE;
      step     <= '0;
      rd_base  <= '0;
      cfg_mode <= MODE_SOBEL;
      cfg_te   <= 1'b0;
      cfg_th   <= '0;
      INT      <= 1'b0;
    end else begin
      rd_state <= rd_state_nxt;
      INT      <= pass_done;
      if (pass_start) begin
        step     <= '0;
        cfg_mode <= (mode == MODE_PASS || mode == MODE_PREWITT) ? mode : MODE_SOBEL;
        cfg_te   <= thresh_en;
        cfg_th   <= thresh;
      end else if (step_issue) begin
        step <= step + STEP_W'(1);
      end
      if (pass_done) rd_base <= line_add(rd_base, 1);
    end
  end

  // --------------------------------------------------------------- line RAMs
  logic [DATA_W-1:0] ram_q [NUM_LINES];
  logic [DATA_W-1:0] row_q [3];
  logic [COL_W-1:0]  rd_addr;

  // Step IMG_W aliases a real column; its data is replaced by the zero pad.
  assign rd_addr = step[COL_W-1:0];

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    line_ram #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
    ) u_ram (
      .clk   (ACLK),
      .we    (wr_fire && (wr_line == LINE_W'(i))),
      .waddr (wr_col),
      .wdata (TDATA_sub),
      .re    (en),
      .raddr (rd_addr),
      .rdata (ram_q[i])
    );
  end

  // Window rows top..bottom are lines rd_base, rd_base+1, rd_base+2.
  always_comb begin
    for (int r = 0; r < 3; r++) row_q[r] = ram_q[line_add(rd_base, r)];
  end

  // ---------------------------------------------------------------- pipeline
  // win[row][col]: col 0 is the oldest (left) column, col 2 the newest.
  logic [2:0][2:0][DATA_W-1:0] win;
  logic s1_valid, s1_pad, s1_emit, s2_emit, s2_last;
  logic [DATA_W-1:0] pix_out;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      s1_valid   <= 1'b0;
      s1_pad     <= 1'b0;
      s1_emit    <= 1'b0;
      s2_emit    <= 1'b0;
      s2_last    <= 1'b0;
      win        <= '0;
      TVALID_man <= 1'b0;
      TDATA_man  <= '0;
      TLAST_man  <= 1'b0;
    end else if (pass_start) begin
      // Pipeline is empty between passes; clearing gives the left zero pad.
      win <= '0;
    end else if (en) begin
      s1_valid <= step_issue;
      s1_pad   <= step_issue && (step == LAST_STEP);
      s1_emit  <= step_issue && (step != '0);
      s2_emit  <= s1_valid & s1_emit;
      s2_last  <= s1_valid & s1_pad;
      if (s1_valid) begin
        for (int r = 0; r < 3; r++)
          win[r] <= {(s1_pad ? '0 : row_q[r]), win[r][2], win[r][1]};
      end
      TVALID_man <= s2_emit;
      TLAST_man  <= s2_emit & s2_last;
      if (s2_emit) TDATA_man <= pix_out;
    end
  end

  // ------------------------------------------------------------------ kernel
  logic signed [GW-1:0] px [3][3];
  logic signed [GW-1:0] cw, gx, gy, ax, ay;
  logic        [GW-1:0] mag;

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        px[r][c] = $signed({{GRAD_GUARD{1'b0}}, win[r][c]});
    cw = (cfg_mode == MODE_PREWITT) ? GW'(PREWITT_CENTRE_W) : GW'(SOBEL_CENTRE_W);
    gx = (px[0][2] + cw * px[1][2] + px[2][2]) - (px[0][0] + cw * px[1][0] + px[2][0]);
    gy = (px[2][0] + cw * px[2][1] + px[2][2]) - (px[0][0] + cw * px[0][1] + px[0][2]);
    ax = gx[GW-1] ? -gx : gx;
    ay = gy[GW-1] ? -gy : gy;
    mag = $unsigned(ax) + $unsigned(ay);

    if (cfg_mode == MODE_PASS)        pix_out = win[1][1];
    else if (cfg_te)                  pix_out = (mag > {{GRAD_GUARD{1'b0}}, cfg_th}) ? '1 : '0;
    else if (|mag[GW-1:DATA_W])       pix_out = '1;
    else                              pix_out = mag[DATA_W-1:0];
  end

endmodule

// File: tb/tb_edge_stream_core.sv
// Scoreboard bench for edge_stream_core at IMG_W=8, NUM_LINES=4, DATA_W=8.
// Completed input lines are recorded; whenever three lines are held, the
// expected output line for the centre is pushed to a queue. A monitor pops
// and compares on every accepted output pixel.
module tb_edge_stream_core;

  localparam int IMG_W     = 8;
  localparam int DATA_W    = 8;
  localparam int NUM_LINES = 4;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic              TVALID_sub = 1'b0;
  logic [DATA_W-1:0] TDATA_sub = '0;
  logic              TREADY_sub;
  logic              TVALID_man;
  logic [DATA_W-1:0] TDATA_man;
  logic              TLAST_man;
  logic              TREADY_man = 1'b1;
  logic [1:0]        mode = 2'd0;
  logic              thresh_en = 1'b0;
  logic [DATA_W-1:0] thresh = '0;
  logic              INT;

  edge_stream_core #(
    .IMG_W     (IMG_W),
    .DATA_W    (DATA_W),
    .NUM_LINES (NUM_LINES)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .TVALID_sub (TVALID_sub),
    .TDATA_sub  (TDATA_sub),
    .TREADY_sub (TREADY_sub),
    .TVALID_man (TVALID_man),
    .TDATA_man  (TDATA_man),
    .TLAST_man  (TLAST_man),
    .TREADY_man (TREADY_man),
    .mode       (mode),
    .thresh_en  (thresh_en),
    .thresh     (thresh),
    .INT        (INT)
  );

  always #5 ACLK = ~ACLK;

  typedef logic [DATA_W-1:0] line_t [IMG_W];
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t  sb_q[$];
  line_t hist[$];
  int    checks = 0;
  int    failures = 0;
  int    int_cnt = 0;
  int    exp_passes = 0;
  int    rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int    gap_pct = 0;    // chance of an idle cycle before each input pixel

  // ------------------------------------------------------------ golden model
  function automatic logic [DATA_W-1:0] golden(input line_t t, input line_t m, input line_t b,
                                               input int c, input logic [1:0] md,
                                               input logic te, input logic [DATA_W-1:0] th);
    int    p [3][3];
    int    gx, gy, w, mag, col;
    line_t rows [3];
    rows[0] = t;
    rows[1] = m;
    rows[2] = b;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) begin
        col = c - 1 + k;
        p[r][k] = (col < 0 || col >= IMG_W) ? 0 : int'(rows[r][col]);
      end
    if (md == 2'd2) return m[c];
    w   = (md == 2'd1) ? 1 : 2;
    gx  = (p[0][2] + w * p[1][2] + p[2][2]) - (p[0][0] + w * p[1][0] + p[2][0]);
    gy  = (p[2][0] + w * p[2][1] + p[2][2]) - (p[0][0] + w * p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (te) return (mag > int'(th)) ? 8'hFF : 8'h00;
    return (mag > 255) ? 8'hFF : 8'(mag);
  endfunction

  task automatic push_line(input line_t ln);
    int   n;
    exp_t e;
    hist.push_back(ln);
    n = hist.size();
    if (n >= 3) begin
      for (int c = 0; c < IMG_W; c++) begin
        e.data = golden(hist[n-3], hist[n-2], hist[n-1], c, mode, thresh_en, thresh);
        e.last = (c == IMG_W - 1);
        sb_q.push_back(e);
      end
      exp_passes++;
    end
  endtask

  // --------------------------------------------------------------- drivers
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      case (rdy_mode)
        0:       TREADY_man = 1'b0;
        1:       TREADY_man = 1'b1;
        default: TREADY_man = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic feed_line(input line_t ln);
    int guard;
    bit acc;
    for (int c = 0; c < IMG_W; c++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        TVALID_sub = 1'b0;
        @(posedge ACLK);
        #1;
      end
      TVALID_sub = 1'b1;
      TDATA_sub  = ln[c];
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge ACLK);
        acc = TREADY_sub;
        @(posedge ACLK);
        #1;
        guard++;
        if (!acc && guard > 2000) begin
          checks++;
          failures++;
          $display("FAIL feed_timeout col=%0d TREADY_sub=%b required 1", c, TREADY_sub);
          TVALID_sub = 1'b0;
          return;
        end
      end
    end
    TVALID_sub = 1'b0;
    push_line(ln);
  endtask

  task automatic fill_const(output line_t ln, input int v);
    for (int c = 0; c < IMG_W; c++) ln[c] = 8'(v);
  endtask

  task automatic fill_rand(output line_t ln, input int hi);
    for (int c = 0; c < IMG_W; c++) ln[c] = 8'($urandom_range(0, hi));
  endtask

  task automatic wait_drain(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (sb_q.size() != 0 && n < 3000) begin
      @(posedge ACLK);
      n++;
    end
    if (sb_q.size() != 0) ok = 1'b0;
    repeat (10) @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge ACLK);
    #1;
    ARESETn    = 1'b0;
    TVALID_sub = 1'b0;
    sb_q.delete();
    hist.delete();
    repeat (3) @(posedge ACLK);
    int_cnt    = 0;
    exp_passes = 0;
    #1;
    ARESETn = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    logic              pv;
    logic              pi;
    logic [DATA_W-1:0] pd;
    logic              pl;
    exp_t              e;
    pv = 1'b0;
    pi = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        pv = 1'b0;
        pi = 1'b0;
      end else begin
        if (pv) begin
          checks++;
          if (TVALID_man !== 1'b1 || TDATA_man !== pd || TLAST_man !== pl) begin
            failures++;
            $display("FAIL stall_hold got v=%b d=%0d l=%b required v=1 d=%0d l=%b",
                     TVALID_man, TDATA_man, TLAST_man, pd, pl);
          end
        end
        if (TVALID_man === 1'b1 && TREADY_man === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output d=%0d l=%b required no output", TDATA_man, TLAST_man);
          end else begin
            e = sb_q.pop_front();
            if (TDATA_man !== e.data || TLAST_man !== e.last) begin
              failures++;
              $display("FAIL pixel got d=%0d l=%b required d=%0d l=%b",
                       TDATA_man, TLAST_man, e.data, e.last);
            end
          end
        end
        if (INT === 1'b1) begin
          int_cnt++;
          checks++;
          if (pi) begin
            failures++;
            $display("FAIL int_width got INT high two cycles required one-cycle pulse");
          end
        end
        pi = INT;
        pv = TVALID_man & ~TREADY_man;
        pd = TDATA_man;
        pl = TLAST_man;
      end
    end
  end

  // ------------------------------------------------------------------ tests
  task automatic check_passes(input string name);
    bit ok;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_drain got %0d pending required 0", name, sb_q.size());
    end
    checks++;
    if (int_cnt != exp_passes) begin
      failures++;
      $display("FAIL %s_int_count got %0d required %0d", name, int_cnt, exp_passes);
    end
  endtask

  task automatic test_reset();
    @(posedge ACLK);
    #1;
    ARESETn = 1'b0;
    repeat (10) begin
      @(negedge ACLK);
      checks++;
      if ({TREADY_sub, TVALID_man, TDATA_man, TLAST_man, INT} !== '0) begin
        failures++;
        $display("FAIL reset_outputs got rdy=%b v=%b d=%0d l=%b int=%b required all 0",
                 TREADY_sub, TVALID_man, TDATA_man, TLAST_man, INT);
      end
    end
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if (TREADY_sub !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready got %b required 0", TREADY_sub);
    end
    @(negedge ACLK);
    checks++;
    if (TREADY_sub !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_after got %b required 1", TREADY_sub);
    end
  endtask

  task automatic test_fill();
    line_t ln;
    int    n;
    do_reset();
    mode = 2'd0; thresh_en = 1'b0; thresh = '0; rdy_mode = 1; gap_pct = 0;
    fill_const(ln, 0);
    repeat (4) feed_line(ln);
    @(negedge ACLK);
    checks++;
    if (TREADY_sub !== 1'b0) begin
      failures++;
      $display("FAIL fill_ready_drop got %b required 0 after 32 pixels", TREADY_sub);
    end
    n = 0;
    while (TREADY_sub !== 1'b1 && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    checks++;
    if (TREADY_sub !== 1'b1) begin
      failures++;
      $display("FAIL fill_ready_return got %b required 1", TREADY_sub);
    end
    @(posedge ACLK);
    #1;
    check_passes("fill");
  endtask

  task automatic test_vertical_step();
    line_t z, h;
    do_reset();
    mode = 2'd0; thresh_en = 1'b0; thresh = '0;
    fill_const(z, 0);
    fill_const(h, 255);
    feed_line(z);
    feed_line(z);
    feed_line(h);
    feed_line(h);
    check_passes("vertical");
  endtask

  task automatic test_prewitt_thresh();
    line_t u;
    do_reset();
    mode = 2'd1; thresh_en = 1'b1; thresh = 8'd50;
    fill_const(u, 100);
    repeat (4) feed_line(u);
    check_passes("prewitt");
  endtask

  task automatic test_passthrough();
    line_t r;
    do_reset();
    mode = 2'd2; thresh_en = 1'b1; thresh = 8'd0;
    repeat (4) begin
      fill_rand(r, 255);
      feed_line(r);
    end
    check_passes("pass");
  endtask

  task automatic test_reserved_mode();
    line_t r;
    do_reset();
    mode = 2'd3; thresh_en = 1'b0; thresh = '0;
    repeat (4) begin
      fill_rand(r, 40);
      feed_line(r);
    end
    check_passes("reserved");
  endtask

  task automatic test_backpressure();
    line_t r;
    do_reset();
    mode = 2'd0; thresh_en = 1'b0; thresh = '0;
    rdy_mode = 2; gap_pct = 30;
    repeat (7) begin
      fill_rand(r, 40);
      feed_line(r);
    end
    check_passes("backpressure");
    rdy_mode = 1; gap_pct = 0;
  endtask

  // Continues from the previous frame without reset: windows straddle old lines.
  task automatic test_back_to_back();
    line_t r;
    mode = 2'd1; thresh_en = 1'b1; thresh = 8'd60;
    repeat (3) begin
      fill_rand(r, 60);
      feed_line(r);
    end
    check_passes("back_to_back");
  endtask

  task automatic test_midframe_reset();
    line_t r;
    do_reset();
    mode = 2'd0; thresh_en = 1'b0; thresh = '0; rdy_mode = 0;
    repeat (4) begin
      fill_rand(r, 255);
      feed_line(r);
    end
    repeat (5) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if (TVALID_man !== 1'b1) begin
      failures++;
      $display("FAIL midreset_stalled got v=%b required 1", TVALID_man);
    end
    do_reset();
    rdy_mode = 1;
    repeat (30) begin
      @(negedge ACLK);
      checks++;
      if (TVALID_man !== 1'b0 || INT !== 1'b0) begin
        failures++;
        $display("FAIL midreset_quiet got v=%b int=%b required 0 0", TVALID_man, INT);
      end
    end
    @(posedge ACLK);
    #1;
    mode = 2'd2;
    repeat (3) begin
      fill_rand(r, 255);
      feed_line(r);
    end
    check_passes("midreset_restart");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_vertical_step();
    test_prewitt_thresh();
    test_passthrough();
    test_reserved_mode();
    test_backpressure();
    test_back_to_back();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
